// File: rtl/output_channel_credit_scheduler_if.sv
// Bundle of the issue/squash/dequeue inputs and the credit status outputs
// exchanged between the trigger stage and the output channel credit scheduler.
`ifndef TIA_NUM_OUTPUT_CHANNELS
`define TIA_NUM_OUTPUT_CHANNELS 8
`endif

interface output_channel_credit_scheduler_if #(
  parameter int NUM_CHANNELS = `TIA_NUM_OUTPUT_CHANNELS,
  parameter int CREDIT_WIDTH = 3
);
  logic                                 issue_valid;
  logic [NUM_CHANNELS-1:0]              issue_oci;
  logic                                 squash_valid;
  logic [NUM_CHANNELS-1:0]              squash_oci;
  logic [NUM_CHANNELS-1:0]              dequeue;
  logic [NUM_CHANNELS-1:0]              channel_available;
  logic [NUM_CHANNELS*CREDIT_WIDTH-1:0] credit_count;
  logic                                 all_idle;
  logic                                 underflow_error;
  logic                                 overflow_error;

  // Trigger stage / consumer side: drives events, observes credit status.
  modport master (
    output issue_valid,
    output issue_oci,
    output squash_valid,
    output squash_oci,
    output dequeue,
    input  channel_available,
    input  credit_count,
    input  all_idle,
    input  underflow_error,
    input  overflow_error
  );

  // Scheduler side: consumes events, publishes credit status.
  modport slave (
    input  issue_valid,
    input  issue_oci,
    input  squash_valid,
    input  squash_oci,
    input  dequeue,
    output channel_available,
    output credit_count,
    output all_idle,
    output underflow_error,
    output overflow_error
  );
endinterface

// File: rtl/output_channel_credit_scheduler.sv
// Per-channel credit counters for the output channels. A credit is taken when
// an instruction writing the channel issues and returned on consumer dequeue
// or instruction squash. Availability and status are decoded from the
// registered counters only, so there is no input-to-output combinational path.
`ifndef TIA_NUM_OUTPUT_CHANNELS
`define TIA_NUM_OUTPUT_CHANNELS 8
`endif

module output_channel_credit_scheduler #(
  parameter int NUM_CHANNELS = `TIA_NUM_OUTPUT_CHANNELS,
  parameter int DEPTH        = 4,
  parameter int CREDIT_WIDTH = $clog2(DEPTH + 1)
) (
  input logic                              clock,
  input logic                              reset,
  output_channel_credit_scheduler_if.slave bus
);

  // Signed width wide enough for credit + 2 returns - 1 take without wrap.
  localparam int SUM_W = CREDIT_WIDTH + 2;
  localparam logic [CREDIT_WIDTH-1:0]        FULL  = CREDIT_WIDTH'(DEPTH);
  localparam logic signed [SUM_W-1:0]        LIMIT = SUM_W'(DEPTH);

  typedef struct packed {
    logic [CREDIT_WIDTH-1:0] credit;
    logic                    under;
    logic                    over;
  } upd_t;

  // Applies one cycle of take/give to a single counter. An issue against an
  // empty channel with nothing coming back consumes nothing and is flagged;
  // a return that would exceed the buffer depth clamps at DEPTH and is flagged.
  function automatic upd_t update_credit(
    input logic [CREDIT_WIDTH-1:0] cur,
    input logic                    take,
    input logic [1:0]              give
  );
    logic signed [SUM_W-1:0] nxt;
    upd_t                    r;
    nxt = $signed({2'b00, cur})
        + $signed({{CREDIT_WIDTH{1'b0}}, give})
        - $signed({{(CREDIT_WIDTH+1){1'b0}}, take});
    r.credit = cur;
    r.under  = 1'b0;
    r.over   = 1'b0;
    if (take && (cur == '0) && (give == 2'd0)) begin
      r.under = 1'b1;
    end else if (nxt > LIMIT) begin
      r.credit = FULL;
      r.over   = 1'b1;
    end else begin
      r.credit = nxt[CREDIT_WIDTH-1:0];
    end
    return r;
  endfunction

  logic [CREDIT_WIDTH-1:0] credit      [NUM_CHANNELS];
  logic [CREDIT_WIDTH-1:0] credit_next [NUM_CHANNELS];
  logic                    any_under;
  logic                    any_over;
  logic                    underflow_q;
  logic                    overflow_q;

  // Next-state for every channel; channels never interact except through
  // the shared sticky error flags.
  always_comb begin
    any_under = 1'b0;
    any_over  = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      logic       take;
      logic [1:0] give;
      upd_t       upd;
      take = bus.issue_valid & bus.issue_oci[i];
      give = {1'b0, bus.dequeue[i]} + {1'b0, bus.squash_valid & bus.squash_oci[i]};
      upd  = update_credit(credit[i], take, give);
      credit_next[i] = upd.credit;
      any_under      = any_under | upd.under;
      any_over       = any_over  | upd.over;
    end
  end

  // Credit and error state; reset restores full credit and discards any
  // in-flight reservations regardless of concurrent traffic.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        credit[i] <= FULL;
      end
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        credit[i] <= credit_next[i];
      end
      underflow_q <= underflow_q | any_under;
      overflow_q  <= overflow_q  | any_over;
    end
  end

  logic [NUM_CHANNELS-1:0]              avail;
  logic [NUM_CHANNELS*CREDIT_WIDTH-1:0] packed_count;
  logic                                 idle;

  // Status decode from registered counters only.
  always_comb begin
    avail        = '0;
    packed_count = '0;
    idle         = 1'b1;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      avail[i] = (credit[i] != '0);
      packed_count[i*CREDIT_WIDTH +: CREDIT_WIDTH] = credit[i];
      if (credit[i] != FULL) idle = 1'b0;
    end
  end

  assign bus.channel_available = avail;
  assign bus.credit_count      = packed_count;
  assign bus.all_idle          = idle;
  assign bus.underflow_error   = underflow_q;
  assign bus.overflow_error    = overflow_q;

endmodule

// File: doc/output_channel_credit_scheduler.md
# output_channel_credit_scheduler

Per-channel credit scheduler for the processing element's output channels. It keeps a registered count of free downstream buffer slots for each output channel. A slot is reserved when an instruction writing that channel issues, and returned when the consumer dequeues or the instruction is squashed. The resulting availability mask feeds the trigger-resolution stage, and downstream full-status updating is layered on top of it, so no issued instruction ever targets a channel without a guaranteed slot.

## Interface
Parameters:
- NUM_CHANNELS, default TIA_NUM_OUTPUT_CHANNELS: number of output channels tracked.
- DEPTH, default 4: slots per downstream channel buffer. Legal range is 1..255.
- CREDIT_WIDTH, default $clog2(DEPTH + 1): width of each credit counter. Derived; do not override.

Ports:
- clock  in  1: sole clock; all state updates on its rising edge.
- reset  in  1: synchronous, active-low reset, sampled on the rising clock edge.
- issue_valid  in  1: an instruction issues from the trigger stage this cycle.
- issue_oci  in  NUM_CHANNELS: output channel index mask of the issuing instruction. Ignored when issue_valid=0.
- squash_valid  in  1: a previously issued instruction is cancelled before writing.
- squash_oci  in  NUM_CHANNELS: OCI mask of the squashed instruction. Ignored when squash_valid=0.
- dequeue  in  NUM_CHANNELS: per-channel pulse; the consumer removed one entry this cycle.
- channel_available  out  NUM_CHANNELS: bit i is 1 iff credit[i] != 0 (registered credits).
- credit_count  out  NUM_CHANNELS*CREDIT_WIDTH: packed counters; channel i occupies bits [i*CREDIT_WIDTH +: CREDIT_WIDTH].
- all_idle  out  1: every credit[i] == DEPTH.
- underflow_error  out  1: sticky; an issue hit a channel with zero credit.
- overflow_error  out  1: sticky; a return would exceed DEPTH.

## Operation
- State consists of one CREDIT_WIDTH counter per channel plus two sticky error flags. There is no other storage.
- Reset (reset=0 at an edge) sets:
  - every credit[i] to DEPTH,
  - channel_available to all ones and all_idle to 1,
  - both error flags to 0.
- Reset takes priority over all other inputs in the same cycle, including mid-operation; in-flight reservations are discarded.
- Per channel i, each cycle, compute:
  - take = issue_valid & issue_oci[i]
  - give = dequeue[i] + (squash_valid & squash_oci[i]), range 0..2
  - next = credit[i] + give - take, evaluated in CREDIT_WIDTH+2 signed arithmetic.
- Boundary rules per channel, with the listed priority:
  - If take=1 and credit[i]=0 and give=0: credit stays 0 and underflow_error is set. The issue consumes nothing.
  - If take=1 and credit[i]=0 and give>=1: the return covers the take. Apply next normally; no error.
  - If next > DEPTH: credit saturates at DEPTH and overflow_error is set.
  - Otherwise: credit[i] <= next.
- Channels are fully independent. A multi-bit issue_oci (broadcast write) reserves one credit on every set channel in the same cycle.
- issue_valid=1 with issue_oci=0 is legal and has no effect.
- Error flags clear only on reset. They never gate the counters.
- Outputs are purely functions of registered state; there is no combinational input-to-output path.

## Timing
- Latency: an event in cycle t is visible on channel_available, credit_count and all_idle from cycle t+1.
- Issue and return of the same channel in the same cycle net out. With credit=1, take=1 and give=1, credit stays 1 and available stays 1.
- Availability is pessimistic by construction. A channel reserved in cycle t is unavailable from t+1 until a return is registered. Upstream must use channel_available of the issuing cycle only.
- The block applies no backpressure. Issue is trusted; violations are reported only through underflow_error.

## Test plan
Configuration for all scenarios: NUM_CHANNELS=4, DEPTH=2.
- **Reset:** hold reset=0 for 2 cycles, then release -> credit_count = {2,2,2,2}, channel_available = 4'b1111, all_idle=1, both errors 0.
- **Exhaust and recover:** issue oci=4'b0001 on two consecutive cycles -> credit[0] = 1 then 0; available[0]=0 from the cycle after the second issue. Then dequeue[0]=1 -> credit[0]=1 and available[0]=1 one cycle later.
- **Broadcast plus simultaneous return:** credits {2,1,1,2}. Issue oci=4'b0110 with dequeue=4'b0010 in the same cycle -> credits {2,1,0,2}, available = 4'b1011, all_idle=0.
- **Underflow:** credit[3]=0, then issue oci=4'b1000 with no return -> credit[3] stays 0 and underflow_error=1 next cycle. The flag stays set through later legal traffic.
- **Overflow and squash:** credit[1]=2. squash oci=4'b0010 plus dequeue[1]=1 -> credit[1]=2 (saturated) and overflow_error=1.
- **Reset mid-operation:** with credits {0,1,2,0} and both errors set, assert reset=0 in the same cycle as issue_valid=1 -> next cycle credits {2,2,2,2}, errors 0, all_idle=1.
